// File: rtl/pattern_lock_detector_if.sv
// Stream/status bundle for pattern_lock_detector.
//   InValid, InData, Clear   : stream source -> detector
//   Locked, PatternHit,
//   ErrCount                 : detector -> monitor
// master = stream source / status consumer, slave = detector.
interface pattern_lock_detector_if #(
    parameter int BUS_WIDTH = 8,
    parameter int ERR_WIDTH = 16
);
    logic                 InValid;
    logic [BUS_WIDTH-1:0] InData;
    logic                 Clear;
    logic                 Locked;
    logic                 PatternHit;
    logic [ERR_WIDTH-1:0] ErrCount;

    modport master (
        output InValid, InData, Clear,
        input  Locked, PatternHit, ErrCount
    );

    modport slave (
        input  InValid, InData, Clear,
        output Locked, PatternHit, ErrCount
    );
endinterface

// File: rtl/pattern_lock_detector.sv
// Multi-word pattern lock detector for a valid-qualified data stream.
// Hunts for PATTERN (word 0 first), locks after N_LOCK back-to-back good
// patterns and drops lock after N_UNLOCK consecutive bad frames. While
// locked, mismatched words are counted in a saturating ErrCount.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous reset, active low
//   bus  : slave side of pattern_lock_detector_if
//          (InValid, InData, Clear in; Locked, PatternHit, ErrCount out)
module pattern_lock_detector #(
    parameter int BUS_WIDTH = 8,
    parameter int PAT_WORDS = 4,
    parameter logic [BUS_WIDTH*PAT_WORDS-1:0] PATTERN = 32'hAABBCCDD,
    parameter int N_LOCK    = 4,
    parameter int N_UNLOCK  = 2,
    parameter int CNT_WIDTH = 4,
    parameter int ERR_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    pattern_lock_detector_if.slave   bus
);
    localparam int IDX_W = $clog2(PAT_WORDS);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(PAT_WORDS - 1);
    localparam logic [BUS_WIDTH-1:0] WORD0     = PATTERN[BUS_WIDTH-1:0];
    // Compare against N-1 so the counter never has to hold N+1.
    localparam logic [CNT_WIDTH-1:0] LOCK_M1   = CNT_WIDTH'(N_LOCK - 1);
    localparam logic [CNT_WIDTH-1:0] UNLOCK_M1 = CNT_WIDTH'(N_UNLOCK - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        LOCKED = 2'b01
    } state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [CNT_WIDTH-1:0] good_cnt, good_n;
    logic [CNT_WIDTH-1:0] bad_cnt, bad_n;
    logic                 frame_err, ferr_n;
    logic [ERR_WIDTH-1:0] err_cnt, err_n;
    logic                 hit_q, hit_n;
    logic                 locked_q;
    logic [BUS_WIDTH-1:0] pat_word;
    logic                 match;
    logic                 last;

    always_comb begin
        pat_word = '0;
        for (int unsigned k = 0; k < PAT_WORDS; k++) begin
            if (idx == IDX_W'(k))
                pat_word = PATTERN[k*BUS_WIDTH +: BUS_WIDTH];
        end
    end

    assign match = (bus.InData == pat_word);
    assign last  = (idx == LAST_IDX);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        good_n  = good_cnt;
        bad_n   = bad_cnt;
        ferr_n  = frame_err;
        err_n   = err_cnt;
        hit_n   = 1'b0;

        if (bus.Clear) begin
            state_n = HUNT;
            idx_n   = '0;
            good_n  = '0;
            bad_n   = '0;
            ferr_n  = 1'b0;
            err_n   = '0;
        end else if (bus.InValid) begin
            case (state)
                HUNT: begin
                    if (match) begin
                        if (last) begin
                            idx_n = '0;
                            hit_n = 1'b1;
                            if (good_cnt == LOCK_M1) begin
                                state_n = LOCKED;
                                good_n  = '0;
                            end else begin
                                good_n = good_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        // A stray word 0 starts a new candidate at once.
                        good_n = '0;
                        idx_n  = (bus.InData == WORD0) ? IDX_W'(1) : '0;
                    end
                end
                LOCKED: begin
                    if (!match && (err_cnt != '1))
                        err_n = err_cnt + ERR_WIDTH'(1);
                    if (last) begin
                        idx_n  = '0;
                        ferr_n = 1'b0;
                        if (match && !frame_err) begin
                            hit_n = 1'b1;
                            bad_n = '0;
                        end else if (bad_cnt == UNLOCK_M1) begin
                            state_n = HUNT;
                            good_n  = '0;
                            bad_n   = '0;
                        end else begin
                            bad_n = bad_cnt + CNT_WIDTH'(1);
                        end
                    end else begin
                        idx_n  = idx + IDX_W'(1);
                        ferr_n = frame_err | ~match;
                    end
                end
                default: begin
                    state_n = HUNT;
                    idx_n   = '0;
                    good_n  = '0;
                    bad_n   = '0;
                    ferr_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= HUNT;
            idx       <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            hit_q     <= 1'b0;
            locked_q  <= 1'b0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            good_cnt  <= good_n;
            bad_cnt   <= bad_n;
            frame_err <= ferr_n;
            err_cnt   <= err_n;
            hit_q     <= hit_n;
            locked_q  <= (state_n == LOCKED);
        end
    end

    assign bus.Locked     = locked_q;
    assign bus.PatternHit = hit_q;
    assign bus.ErrCount   = err_cnt;
endmodule

// File: tb/tb_pattern_lock_detector.sv
// Directed testbench for pattern_lock_detector.
//   u1: default parameters
//   u2: N_LOCK=1, ERR_WIDTH=4 (saturation reachable in few cycles)
//   u3: BUS_WIDTH=16, PAT_WORDS=3, PATTERN=48'h123456789ABC, N_LOCK=2
module tb_pattern_lock_detector;
    logic CLK;
    logic RST;
    logic rst3;
    int   checks;
    int   errors;

    pattern_lock_detector_if #(.BUS_WIDTH(8),  .ERR_WIDTH(16)) if1 ();
    pattern_lock_detector_if #(.BUS_WIDTH(8),  .ERR_WIDTH(4))  if2 ();
    pattern_lock_detector_if #(.BUS_WIDTH(16), .ERR_WIDTH(16)) if3 ();

    pattern_lock_detector u1 (.CLK(CLK), .RST(RST), .bus(if1.slave));

    pattern_lock_detector #(.N_LOCK(1), .ERR_WIDTH(4)) u2 (
        .CLK(CLK), .RST(RST), .bus(if2.slave));

    pattern_lock_detector #(
        .BUS_WIDTH(16), .PAT_WORDS(3), .PATTERN(48'h123456789ABC), .N_LOCK(2)
    ) u3 (.CLK(CLK), .RST(rst3), .bus(if3.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic s1(input logic v, input logic [7:0] d, input logic c,
                      input logic eh, input logic el, input logic [15:0] ee, input string tag);
        if1.InValid = v; if1.InData = d; if1.Clear = c;
        @(posedge CLK); #1;
        if1.InValid = 1'b0; if1.Clear = 1'b0;
        chk({tag, ".hit"}, 32'(if1.PatternHit), 32'(eh));
        chk({tag, ".lock"}, 32'(if1.Locked), 32'(el));
        chk({tag, ".err"}, 32'(if1.ErrCount), 32'(ee));
    endtask

    task automatic s2(input logic v, input logic [7:0] d, input logic c,
                      input logic eh, input logic el, input logic [3:0] ee, input string tag);
        if2.InValid = v; if2.InData = d; if2.Clear = c;
        @(posedge CLK); #1;
        if2.InValid = 1'b0; if2.Clear = 1'b0;
        chk({tag, ".hit"}, 32'(if2.PatternHit), 32'(eh));
        chk({tag, ".lock"}, 32'(if2.Locked), 32'(el));
        chk({tag, ".err"}, 32'(if2.ErrCount), 32'(ee));
    endtask

    task automatic s3(input logic [15:0] d, input logic eh, input logic el,
                      input logic [15:0] ee, input string tag);
        if3.InValid = 1'b1; if3.InData = d; if3.Clear = 1'b0;
        @(posedge CLK); #1;
        if3.InValid = 1'b0;
        chk({tag, ".hit"}, 32'(if3.PatternHit), 32'(eh));
        chk({tag, ".lock"}, 32'(if3.Locked), 32'(el));
        chk({tag, ".err"}, 32'(if3.ErrCount), 32'(ee));
    endtask

    logic [7:0]  p1 [4];
    logic [15:0] p3 [3];

    initial begin
        checks = 0;
        errors = 0;
        p1 = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        p3 = '{16'h9ABC, 16'h5678, 16'h1234};
        RST = 1'b0; rst3 = 1'b0;
        if1.InValid = 1'b0; if1.InData = '0; if1.Clear = 1'b0;
        if2.InValid = 1'b0; if2.InData = '0; if2.Clear = 1'b0;
        if3.InValid = 1'b0; if3.InData = '0; if3.Clear = 1'b0;
        #12;
        chk("rst.hit",  32'(if1.PatternHit), 32'd0);
        chk("rst.lock", 32'(if1.Locked), 32'd0);
        chk("rst.err",  32'(if1.ErrCount), 32'd0);
        @(negedge CLK);
        RST = 1'b1; rst3 = 1'b1;

        // ---------------- u1: lock on 16th word ----------------
        for (int p = 0; p < 4; p++)
            for (int w = 0; w < 4; w++)
                s1(1'b1, p1[w], 1'b0, w == 3, (p == 3) && (w == 3), 16'd0, "lockA");

        // Two bad frames: lock falls on the last word of the second.
        s1(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 16'd0, "bad1.w0");
        s1(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd1, "bad1.w1");
        s1(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 16'd1, "bad1.w2");
        s1(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 16'd1, "bad1.w3");
        s1(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 16'd1, "bad2.w0");
        s1(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 16'd1, "bad2.w1");
        s1(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd2, "bad2.w2");
        s1(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 16'd2, "bad2.w3");

        // Patterns straight after the drop relock; ErrCount holds.
        for (int p = 0; p < 4; p++)
            for (int w = 0; w < 4; w++)
                s1(1'b1, p1[w], 1'b0, w == 3, (p == 3) && (w == 3), 16'd2, "relock");

        // One bad frame then a good one keeps lock.
        s1(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 16'd2, "one.w0");
        s1(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 16'd2, "one.w1");
        s1(1'b1, 8'hBB, 1'b0, 1'b0, 1'b1, 16'd2, "one.w2");
        s1(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 16'd3, "one.w3");
        for (int w = 0; w < 4; w++)
            s1(1'b1, p1[w], 1'b0, w == 3, 1'b1, 16'd3, "keep");

        // Clear mid-frame overrides InValid/data.
        s1(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 16'd3, "pre.w0");
        s1(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 16'd3, "pre.w1");
        s1(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 16'd0, "clear1");

        // Re-sync on repeated word 0; HUNT mismatches do not count errors.
        s1(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 16'd0, "rs.w0");
        s1(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 16'd0, "rs.w0b");
        s1(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 16'd0, "rs.w1");
        s1(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 16'd0, "rs.w2");
        s1(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 16'd0, "rs.w3");
        s1(1'b1, 8'hDD, 1'b0, 1'b0, 1'b0, 16'd0, "brk.w0");
        s1(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0, 16'd0, "brk.w1");
        s1(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0, "brk.w2");
        s1(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 16'd0, "brk.w3");
        // good_cnt was reset: three more patterns must not lock, the fourth does.
        for (int p = 0; p < 4; p++)
            for (int w = 0; w < 4; w++)
                s1(1'b1, p1[w], 1'b0, w == 3, (p == 3) && (w == 3), 16'd0, "post");

        // Clear with InValid low, then lock with 3-cycle gaps.
        s1(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0, "clear2");
        for (int p = 0; p < 4; p++)
            for (int w = 0; w < 4; w++) begin
                s1(1'b1, p1[w], 1'b0, w == 3, (p == 3) && (w == 3), 16'd0, "gapw");
                for (int g = 0; g < 3; g++)
                    s1(1'b0, 8'h00, 1'b0, 1'b0, (p == 3) && (w == 3), 16'd0, "gapi");
            end

        // ---------------- u2: N_LOCK=1, 4-bit ErrCount ----------------
        for (int w = 0; w < 4; w++)
            s2(1'b1, p1[w], 1'b0, w == 3, w == 3, 4'd0, "u2.lock");
        for (int r = 0; r < 5; r++) begin
            for (int w = 0; w < 4; w++) begin
                int e;
                e = 4 * r + w + 1;
                if (e > 15) e = 15;
                s2(1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 4'(e), "u2.bad");
            end
            for (int w = 0; w < 4; w++) begin
                int e;
                e = 4 * r + 4;
                if (e > 15) e = 15;
                s2(1'b1, p1[w], 1'b0, w == 3, 1'b1, 4'(e), "u2.good");
            end
        end
        s2(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1, 4'hF, "u2.pre0");
        s2(1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 4'hF, "u2.pre1");
        s2(1'b1, 8'hBB, 1'b1, 1'b0, 1'b0, 4'h0, "u2.clear");

        // ---------------- u3: 16-bit, 3-word, N_LOCK=2 ----------------
        for (int p = 0; p < 2; p++)
            for (int w = 0; w < 3; w++)
                s3(p3[w], w == 2, (p == 1) && (w == 2), 16'd0, "u3.lock");
        s3(16'h9ABC, 1'b0, 1'b1, 16'd0, "u3.bad0");
        s3(16'h0000, 1'b0, 1'b1, 16'd1, "u3.bad1");
        s3(16'h1234, 1'b0, 1'b1, 16'd1, "u3.bad2");
        for (int w = 0; w < 3; w++)
            s3(p3[w], w == 2, 1'b1, 16'd1, "u3.good");
        // Asynchronous reset between edges clears outputs at once.
        #2 rst3 = 1'b0;
        #1;
        chk("u3.arst.hit",  32'(if3.PatternHit), 32'd0);
        chk("u3.arst.lock", 32'(if3.Locked), 32'd0);
        chk("u3.arst.err",  32'(if3.ErrCount), 32'd0);
        @(negedge CLK);
        rst3 = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pattern_lock_detector.md
Name: pattern_lock_detector

Overview:
Parametrised successor to the fixed 4-byte, one-shot pattern detector in the PRBS-15 checker path. It detects a multi-word pattern of configurable length and bus width in a valid-qualified data stream. It declares lock after N_LOCK consecutive back-to-back patterns and drops lock after N_UNLOCK consecutive corrupted frames. While locked it counts word errors for BER-style monitoring, and lock can be lost and reacquired without a reset.

Parameters:
BUS_WIDTH, 8, width of InData and of each pattern word
PAT_WORDS, 4, pattern length in words (>=2)
PATTERN, 32'hAABBCCDD, BUS_WIDTH*PAT_WORDS bits; word k = PATTERN[k*BUS_WIDTH +: BUS_WIDTH]; word 0 arrives first
N_LOCK, 4, consecutive good patterns required to lock (>=1)
N_UNLOCK, 2, consecutive bad frames that drop lock (>=1)
CNT_WIDTH, 4, width of good/bad frame counters (must hold N_LOCK and N_UNLOCK)
ERR_WIDTH, 16, width of ErrCount

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous, active-low reset
InValid  in  1  qualifies InData; state holds when low
InData  in  BUS_WIDTH  data word
Clear  in  1  synchronous clear to HUNT
Locked  out  1  registered lock status
PatternHit  out  1  registered one-cycle pulse per fully correct pattern
ErrCount  out  ERR_WIDTH  saturating count of mismatched words while locked

Behaviour:
- Reset (RST=0): state=HUNT; word index idx=0; good_cnt=0; bad_cnt=0; frame_err=0; Locked=0; PatternHit=0; ErrCount=0.
- All outputs are registered. Only cycles with InValid=1 advance the logic. With InValid=0, everything holds, except PatternHit, which is 0.
- Clear=1 behaves as reset on the next edge and overrides InValid.
- HUNT state (Locked=0):
  - Match of PATTERN word idx with idx<PAT_WORDS-1: idx++.
  - Match at idx=PAT_WORDS-1: idx=0, PatternHit=1, good_cnt++. If good_cnt+1==N_LOCK, go to LOCKED, set Locked=1, clear good_cnt.
  - Mismatch: good_cnt=0. If InData==word 0, idx=1 (immediate re-sync); else idx=0.
  - Patterns must be back-to-back. Any non-pattern word between two patterns resets good_cnt.
- LOCKED state (Locked=1):
  - Alignment is fixed. idx advances on every valid word regardless of match and wraps at PAT_WORDS-1. There is no re-sync inside a frame.
  - Each mismatched word sets frame_err and increments ErrCount. ErrCount saturates at all-ones and is cleared only by reset or Clear.
  - At the frame's last word: if there is no error in the frame (including the last word), PatternHit=1 and bad_cnt=0. Otherwise bad_cnt++.
  - When bad_cnt+1==N_UNLOCK: go to HUNT, Locked=0, idx=0, good_cnt=0, bad_cnt=0.
  - frame_err clears at every frame boundary.
- Latency:
  - Locked rises on the edge that samples the last word of the N_LOCK-th good pattern.
  - PatternHit is high for the cycle after the final word is sampled.
  - Locked falls on the edge that samples the last word of the N_UNLOCK-th bad frame.
- Edge cases:
  - With N_LOCK=1, the first good pattern locks.
  - ErrCount does not increment in HUNT.
  - A lock drop followed immediately by a valid pattern restarts HUNT counting from word 0 on the next word.
  - Out-of-range state goes to HUNT.

Test Plan:
- Defaults: send AA? No — send DD,CC,BB,AA ×4 back-to-back with InValid=1. Required response: PatternHit pulses 4 times, and Locked=1 on the edge sampling the 16th word.
- Send DD,DD,CC,BB,AA. Required response: the second DD re-syncs (idx=1) and the pattern is counted. Then send DD,CC,00,AA. Required response: good_cnt resets and there is no lock.
- Insert InValid=0 gaps of 3 cycles between every word of 4 patterns. Required response: lock occurs exactly as without gaps, and PatternHit is 0 in gap cycles.
- When locked, send 2 frames, each with one corrupted word. Required response: ErrCount=2, and Locked falls after the second frame's last word. A single bad frame followed by a good frame keeps Locked=1 (bad_cnt cleared).
- When locked, force more than 65535 errors. Required response: ErrCount holds at 16'hFFFF. Pulse Clear mid-frame. Required response: next cycle Locked=0 and ErrCount=0.
- Override to BUS_WIDTH=16, PAT_WORDS=3, PATTERN=48'h123456789ABC, N_LOCK=2. Required response: lock after words 9ABC,5678,1234 ×2. Pulse RST mid-frame. Required response: all outputs are 0 immediately.
